serial_add_arbiter: RTL and testbench

//  Two-requester front end that owns one bit-serial adder datapath and shares it between callers.

---
 rtl/serial_add_pkg.sv | 13 +
 rtl/serial_add_core.sv | 55 +++++
 rtl/serial_add_arbiter.sv | 114 +++++++++++
 tb/tb_serial_add_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder arbiter: FSM encoding and requester indices.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/serial_add_core.sv
// Bit-serial adder datapath: A/B PISO shift registers, full adder, carry register and
// right-shifting SIPO result register.
// Ports: clk_i clock; clr_i sync clear of all state; load_i loads operands and clears
//        carry/result; shift_en_i performs one LSB-first add step; a_i/b_i operands;
//        sum_o result register; cout_o carry register.
module serial_add_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic             shift_en_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    logic [WIDTH-1:0] a_q, b_q, res_q, res_d;
    logic             carry_q, carry_d, sum_bit;

    // Full adder on the current LSBs
    assign sum_bit = a_q[0] ^ b_q[0] ^ carry_q;
    assign carry_d = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);

    // Result shifts right with the new sum bit entering at the MSB; after WIDTH steps
    // the LSB-first stream lands in natural bit order.
    always_comb begin
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = sum_bit;
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else if (load_i) begin
            a_q     <= a_i;
            b_q     <= b_i;
            res_q   <= '0;
            carry_q <= 1'b0;
        end else if (shift_en_i) begin
            a_q     <= a_q >> 1;
            b_q     <= b_q >> 1;
            res_q   <= res_d;
            carry_q <= carry_d;
        end
    end

    assign sum_o  = res_q;
    assign cout_o = carry_q;

endmodule

// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end sharing one bit-serial adder.
// Ports: clock/rst (sync, active-low); req0_*/req1_* operand ports with valid/ready;
//        rsp_valid/rsp_ready result handshake with rsp_sum, rsp_cout, rsp_id; busy = not idle.
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_sum,
    output logic             rsp_cout,
    output logic             rsp_id,
    output logic             busy
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e        state_q;
    logic          last_grant_q;
    logic [CW-1:0] count_q;
    logic          rsp_id_q, rsp_valid_q, busy_q;

    logic             grant_c, idle_c, accept_c;
    logic [WIDTH-1:0] a_sel_c, b_sel_c;

    // Round-robin: a lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant_c = REQ0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else if (req1_valid) begin
            grant_c = REQ1;
        end
    end

    assign idle_c     = (state_q == ST_IDLE);
    assign req0_ready = idle_c && req0_valid && (grant_c == REQ0);
    assign req1_ready = idle_c && req1_valid && (grant_c == REQ1);
    assign accept_c   = req0_ready || req1_ready;
    assign a_sel_c    = (grant_c == REQ1) ? req1_a : req0_a;
    assign b_sel_c    = (grant_c == REQ1) ? req1_b : req0_b;

    // Sequencer: grant/load, WIDTH shift steps, then hold the response until taken
    always_ff @(posedge clock) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= REQ1;
            count_q      <= '0;
            rsp_id_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        state_q      <= ST_SHIFT;
                        count_q      <= '0;
                        rsp_id_q     <= grant_c;
                        last_grant_q <= grant_c;
                        busy_q       <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    count_q <= count_q + CW'(1);
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_q     <= ST_DONE;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    serial_add_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk_i     (clock),
        .clr_i     (!rst),
        .load_i    (accept_c),
        .shift_en_i(state_q == ST_SHIFT),
        .a_i       (a_sel_c),
        .b_i       (b_sel_c),
        .sum_o     (rsp_sum),
        .cout_o    (rsp_cout)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Directed bench for serial_add_arbiter: WIDTH=8 main instance plus WIDTH=1 and WIDTH=16 builds.
module tb_serial_add_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       r0v, r0r, r1v, r1r, rspv, rsprdy, rcout, rid, busy;
    logic [7:0] r0a, r0b, r1a, r1b, rsum;

    serial_add_arbiter #(.WIDTH(8)) dut (
        .clock(clk), .rst(rst),
        .req0_valid(r0v), .req0_ready(r0r), .req0_a(r0a), .req0_b(r0b),
        .req1_valid(r1v), .req1_ready(r1r), .req1_a(r1a), .req1_b(r1b),
        .rsp_valid(rspv), .rsp_ready(rsprdy), .rsp_sum(rsum), .rsp_cout(rcout),
        .rsp_id(rid), .busy(busy)
    );

    logic       w1v, w1r, w1v1, w1r1, w1rv, w1c, w1id, w1busy, w1rdy;
    logic [0:0] w1a, w1b, w1a1, w1b1, w1s;

    serial_add_arbiter #(.WIDTH(1)) dut_w1 (
        .clock(clk), .rst(rst),
        .req0_valid(w1v), .req0_ready(w1r), .req0_a(w1a), .req0_b(w1b),
        .req1_valid(w1v1), .req1_ready(w1r1), .req1_a(w1a1), .req1_b(w1b1),
        .rsp_valid(w1rv), .rsp_ready(w1rdy), .rsp_sum(w1s), .rsp_cout(w1c),
        .rsp_id(w1id), .busy(w1busy)
    );

    logic        w16v, w16r, w16v1, w16r1, w16rv, w16c, w16id, w16busy, w16rdy;
    logic [15:0] w16a, w16b, w16a1, w16b1, w16s;

    serial_add_arbiter #(.WIDTH(16)) dut_w16 (
        .clock(clk), .rst(rst),
        .req0_valid(w16v), .req0_ready(w16r), .req0_a(w16a), .req0_b(w16b),
        .req1_valid(w16v1), .req1_ready(w16r1), .req1_a(w16a1), .req1_b(w16b1),
        .rsp_valid(w16rv), .rsp_ready(w16rdy), .rsp_sum(w16s), .rsp_cout(w16c),
        .rsp_id(w16id), .busy(w16busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called just after the accept edge; returns edges counted until rsp_valid (accept edge = 1)
    task automatic wait_rsp(output int n);
        n = 1;
        @(negedge clk);
        while (!rspv && n < 40) begin
            @(negedge clk);
            n++;
        end
    endtask

    // One WIDTH=8 transaction from a single port; returns at the negedge where rsp_valid is high
    task automatic run_op(input logic port, input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] exp_s, input logic exp_c);
        int n;
        @(posedge clk); #1;
        if (port) begin r1v = 1'b1; r1a = a; r1b = b; end
        else      begin r0v = 1'b1; r0a = a; r0b = b; end
        n = 0;
        @(negedge clk);
        while (!(port ? r1r : r0r) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("grant_ready", 32'(port ? r1r : r0r), 1);
        check("other_ready", 32'(port ? r0r : r1r), 0);
        @(posedge clk); #1;
        r0v = 1'b0;
        r1v = 1'b0;
        wait_rsp(n);
        check("latency", 32'(n), 9);
        check("sum", 32'(rsum), 32'(exp_s));
        check("cout", 32'(rcout), 32'(exp_c));
        check("id", 32'(rid), 32'(port));
        check("busy_done", 32'(busy), 1);
    endtask

    initial begin
        int n;
        rst = 1'b0; rsprdy = 1'b1;
        r0v = 0; r1v = 0; r0a = 0; r0b = 0; r1a = 0; r1b = 0;
        w1v = 0; w1v1 = 0; w1a = 0; w1b = 0; w1a1 = 0; w1b1 = 0; w1rdy = 1;
        w16v = 0; w16v1 = 0; w16a = 0; w16b = 0; w16a1 = 0; w16b1 = 0; w16rdy = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(rspv), 0);
        check("rst_sum", 32'(rsum), 0);
        check("rst_cout", 32'(rcout), 0);
        check("rst_id", 32'(rid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ready", 32'({r0r, r1r}), 0);
        @(posedge clk); #1 rst = 1'b1;

        // Basic adds and overflow
        run_op(1'b0, 8'h35, 8'h1C, 8'h51, 1'b0);
        run_op(1'b1, 8'hFF, 8'h01, 8'h00, 1'b1);
        run_op(1'b1, 8'h80, 8'h80, 8'h00, 1'b1);

        // Both valid continuously: grants alternate starting with req0
        @(posedge clk); #1;
        r0v = 1; r0a = 8'h12; r0b = 8'h34;
        r1v = 1; r1a = 8'hF0; r1b = 8'h20;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            @(negedge clk);
            while (!(r0r | r1r) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("tie_onehot", 32'(r0r ^ r1r), 1);
            check("tie_grant", 32'(r1r), 32'(k % 2));
            @(posedge clk);
            wait_rsp(n);
            check("rr_latency", 32'(n), 9);
            check("rr_id", 32'(rid), 32'(k % 2));
            check("rr_sum", 32'(rsum), (k % 2) ? 32'h10 : 32'h46);
            check("rr_cout", 32'(rcout), 32'(k % 2));
        end
        @(posedge clk); #1;
        r0v = 0; r1v = 0;

        // Backpressure: response held, no grants while DONE
        rsprdy = 1'b0;
        run_op(1'b0, 8'h0F, 8'hF1, 8'h00, 1'b1);
        @(posedge clk); #1;
        r1v = 1; r1a = 8'h01; r1b = 8'h02;
        repeat (5) begin
            @(negedge clk);
            check("hold_valid", 32'(rspv), 1);
            check("hold_sum", 32'(rsum), 0);
            check("hold_cout", 32'(rcout), 1);
            check("hold_id", 32'(rid), 0);
            check("hold_ready", 32'({r0r, r1r}), 0);
        end
        @(posedge clk); #1;
        r1v = 0; rsprdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_valid", 32'(rspv), 0);
        check("release_busy", 32'(busy), 0);

        // Reset during the 4th SHIFT cycle of a req0 op
        @(posedge clk); #1;
        r0v = 1; r0a = 8'h55; r0b = 8'h0A;
        @(negedge clk);
        check("mid_ready", 32'(r0r), 1);
        @(posedge clk); #1 r0v = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        r0v = 1; r1v = 1; r1a = 8'h01; r1b = 8'h01;
        @(negedge clk);
        check("mrst_busy", 32'(busy), 0);
        check("mrst_valid", 32'(rspv), 0);
        check("mrst_sum", 32'(rsum), 0);
        check("mrst_cout", 32'(rcout), 0);
        check("mrst_id", 32'(rid), 0);
        check("mrst_tie", 32'({r0r, r1r}), 32'b10);
        @(posedge clk); #1;
        r0v = 0; r1v = 0;
        wait_rsp(n);
        check("mrst_op_lat", 32'(n), 9);
        check("mrst_op_sum", 32'(rsum), 32'h5F);
        check("mrst_op_id", 32'(rid), 0);

        // WIDTH=1 and WIDTH=16 builds
        @(posedge clk); #1;
        w1v = 1; w1a = 1'b1; w1b = 1'b1;
        w16v = 1; w16a = 16'hFFFF; w16b = 16'h0001;
        @(negedge clk);
        check("w1_ready", 32'(w1r), 1);
        check("w16_ready", 32'(w16r), 1);
        @(posedge clk); #1;
        w1v = 0; w16v = 0;
        n = 1;
        @(negedge clk);
        check("w1_early", 32'(w1rv), 0);
        @(negedge clk);
        n = 2;
        check("w1_valid", 32'(w1rv), 1);
        check("w1_sum", 32'(w1s), 0);
        check("w1_cout", 32'(w1c), 1);
        while (!w16rv && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("w16_latency", 32'(n), 17);
        check("w16_sum", 32'(w16s), 0);
        check("w16_cout", 32'(w16c), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
